apb_master_arbiter: RTL and testbench

Round-robin APB master that shares one APB bus among `NREQ` local requesters and sequences the APB SETUP/ACCESS protocol toward `apb_slave` or any APB completer. Each requester posts one single-beat read or write and holds it until acknowledged. The block arbitrates, drives the APB phases, waits on PREADY with a bounded timeout, and returns read data and error status to the winner. It sits between the on-chip command sources and the APB peripheral segment.

---
 rtl/apb_master_arbiter_pkg.sv | 27 ++
 rtl/apb_master_arbiter_rr.sv | 46 ++++
 rtl/apb_master_arbiter.sv | 175 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_arbiter_pkg
//
// Shared definitions for the round-robin APB master and its arbiter:
//   apb_state_e          - APB master phase encoding (IDLE / SETUP / ACCESS)
//   APB_AW_DEFAULT       - default APB address width
//   APB_DW_DEFAULT       - default APB data width
//   APB_TIMEOUT_DEFAULT  - default PREADY wait limit in ACCESS cycles
//   idx_width()          - width of an index into N requesters (never 0)

package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW_DEFAULT      = 8;
    localparam int APB_DW_DEFAULT      = 32;
    localparam int APB_TIMEOUT_DEFAULT = 16;

    // A single requester still needs a 1-bit index, hence the floor of 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// rr_arbiter
//
// Purely combinational round-robin picker. The search starts one position
// after the previous winner and wraps modulo NREQ, so a requester that has
// just been served is considered last.
//
// Ports:
//   i_req        [NREQ]  requests that are allowed to win this cycle
//   i_last       [IW]    index of the previous winner
//   o_grant      [NREQ]  one-hot winner, all zero when nothing requests
//   o_grant_idx  [IW]    binary index of the winner (0 when no winner)

module rr_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the requesters in rotating order starting at last+1 and keep the
    // first hit. The walk ends on i_last itself, so a lone requester that won
    // last time can still win again.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(i_last) + i) % NREQ);
            if (!found && i_req[cand]) begin
                found          = 1'b1;
                o_grant[cand]  = 1'b1;
                o_grant_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//
// Shares one APB bus among NREQ local requesters. Each requester holds a
// single-beat read or write on i_req until it sees its o_ack pulse. The block
// arbitrates round-robin in IDLE, runs SETUP then ACCESS, waits on PREADY for
// at most TIMEOUT cycles (0 = wait forever), and returns read data and error
// status to the winner together with a one-cycle o_ack. Every output is
// registered.
//
// Ports:
//   i_clk, i_reset_n                 clock, synchronous active-low reset
//   i_req, i_req_write               per-requester request and direction
//   i_req_addr, i_req_wdata          per-requester address / write data,
//                                    requester k at [k*AW +: AW] / [k*DW +: DW]
//   o_ack, o_rdata, o_slverr         completion pulse (one-hot) and result
//   o_paddr, o_pwrite, o_pwdata,
//   o_psel, o_penable                APB master outputs
//   i_prdata, i_pready, i_pslverr    APB completer responses

module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = APB_AW_DEFAULT,
    parameter int DW      = APB_DW_DEFAULT,
    parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_req_write,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]    o_ack,
    output logic [DW-1:0]      o_rdata,
    output logic               o_slverr,
    output logic [AW-1:0]      o_paddr,
    output logic               o_pwrite,
    output logic [DW-1:0]      o_pwdata,
    output logic               o_psel,
    output logic               o_penable,
    input  logic [DW-1:0]      i_prdata,
    input  logic               i_pready,
    input  logic               i_pslverr
);

    localparam int IW  = idx_width(NREQ);
    localparam int WCW = $clog2(TIMEOUT + 2);
    // The counter reads TIMEOUT-1 during the last permitted ACCESS cycle.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e      state;
    apb_state_e      state_next;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   last;
    logic [NREQ-1:0] winner_oh;
    logic [WCW-1:0]  wait_cnt;
    logic            timeout_hit;
    logic            start;
    logic            finish;

    // A requester being acknowledged this cycle still has i_req high; masking
    // it keeps the same transfer from being granted a second time.
    assign eligible    = i_req & ~o_ack;
    assign timeout_hit = (TIMEOUT != 0) && !i_pready && (wait_cnt == WAIT_LAST);
    assign start       = (state == APB_IDLE) && (|eligible);
    assign finish      = (state == APB_ACCESS) && (i_pready || timeout_hit);

    rr_arbiter #(
        .NREQ        (NREQ)
    ) u_rr_arbiter (
        .i_req       (eligible),
        .i_last      (last),
        .o_grant     (grant),
        .o_grant_idx (grant_idx)
    );

    // Phase sequencing. IDLE always sits between two transfers, so there is
    // no ACCESS->SETUP shortcut even when another requester is waiting.
    always_comb begin
        state_next = state;
        case (state)
            APB_IDLE:   if (start)  state_next = APB_SETUP;
            APB_SETUP:              state_next = APB_ACCESS;
            APB_ACCESS: if (finish) state_next = APB_IDLE;
            default:                state_next = APB_IDLE;
        endcase
    end

    // Phase register. Reset drops straight back to IDLE, abandoning any
    // transfer on the bus without an acknowledge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= APB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus and result registers. The winner's request is captured once at
    // grant so the requester may change its inputs while the transfer runs.
    // psel/penable are driven here as registers to keep every output free of
    // combinational paths from the inputs. A timeout completes the transfer
    // exactly like PREADY would, but reports an error and zero data; any
    // PREADY that arrives afterwards lands in IDLE and is ignored.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            last      <= IW'(NREQ - 1);
            winner_oh <= '0;
            wait_cnt  <= '0;
            o_ack     <= '0;
            o_rdata   <= '0;
            o_slverr  <= 1'b0;
            o_paddr   <= '0;
            o_pwrite  <= 1'b0;
            o_pwdata  <= '0;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
        end else begin
            o_ack <= '0;

            if (start) begin
                last      <= grant_idx;
                winner_oh <= grant;
                o_paddr   <= i_req_addr[int'(grant_idx)*AW +: AW];
                o_pwdata  <= i_req_wdata[int'(grant_idx)*DW +: DW];
                o_pwrite  <= i_req_write[grant_idx];
                o_psel    <= 1'b1;
                o_penable <= 1'b0;
            end

            if (state == APB_SETUP) begin
                o_penable <= 1'b1;
                wait_cnt  <= '0;
            end

            if (state == APB_ACCESS) begin
                if (finish) begin
                    o_psel    <= 1'b0;
                    o_penable <= 1'b0;
                    o_ack     <= winner_oh;
                    if (i_pready) begin
                        o_rdata  <= o_pwrite ? '0 : i_prdata;
                        o_slverr <= i_pslverr;
                    end else begin
                        o_rdata  <= '0;
                        o_slverr <= 1'b1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + WCW'(1);
                end
            end
        end
    end

`ifdef FORMAL
    a_penable_needs_psel: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_penable |-> o_psel);
    a_ack_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_ack));
    a_ack_only_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (|o_ack) |-> (state == APB_IDLE) && !o_psel);
    a_setup_to_access: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (state == APB_SETUP) |=> (state == APB_ACCESS));
    a_access_outputs: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (state == APB_ACCESS) |-> (o_psel && o_penable));
    a_stable_in_access: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (state == APB_ACCESS) |-> ($stable(o_paddr) && $stable(o_pwdata) && $stable(o_pwrite)));
    a_no_double_ack: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (|o_ack) |=> ((o_ack & $past(o_ack)) == '0));
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
//
// Randomised bench. Requesters post random reads/writes, keep or drop i_req
// in the ack cycle, and scramble their inputs while their transfer is in
// flight. The bench plays the APB completer, choosing each transfer's wait
// count up front (zero waits, short waits, TIMEOUT-1 waits, or stuck low).
// The reference model is a transaction timeline: a grant in cycle g gives
// SETUP at g+1, ACCESS from g+2 to the completion cycle, and the ack in the
// cycle after that. Occasional resets land in the middle of ACCESS.

module tb_apb_master_arbiter;

    localparam int NREQ    = 3;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 2500;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               slverr;
    logic [AW-1:0]      paddr;
    logic               pwrite;
    logic [DW-1:0]      pwdata;
    logic               psel;
    logic               penable;
    logic [DW-1:0]      prdata;
    logic               pready;
    logic               pslverr;

    int checks   = 0;
    int failures = 0;

    // Requester-side state
    bit             active   [NREQ];
    bit             op_write [NREQ];
    logic [AW-1:0]  op_addr  [NREQ];
    logic [DW-1:0]  op_wdata [NREQ];

    // Reference model state
    bit             busy;
    int             tx_idx, tx_g, tx_end;
    bit             tx_timeout, tx_write;
    logic [AW-1:0]  tx_addr;
    logic [DW-1:0]  tx_wdata;
    int             last;
    int             free_at;
    int             ack_cyc, ack_idx;
    logic [DW-1:0]  res_rdata, held_rdata;
    bit             res_err, held_err;
    int             zero_cyc;
    int             late_pready_cyc;
    int             mid_resets;

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .NREQ        (NREQ),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req       (req),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_ack       (ack),
        .o_rdata     (rdata),
        .o_slverr    (slverr),
        .o_paddr     (paddr),
        .o_pwrite    (pwrite),
        .o_pwdata    (pwdata),
        .o_psel      (psel),
        .o_penable   (penable),
        .i_prdata    (prdata),
        .i_pready    (pready),
        .i_pslverr   (pslverr)
    );

    // Single comparison point: counts every check, reports each mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [NREQ-1:0] req_v,
                                 input logic [NREQ-1:0] wr_v, input logic [NREQ*AW-1:0] addr_v,
                                 input logic [NREQ*DW-1:0] wd_v, input logic pr_v,
                                 input logic [DW-1:0] prd_v, input logic perr_v);
        reset_n   = rst_v;
        req       = req_v;
        req_write = wr_v;
        req_addr  = addr_v;
        req_wdata = wd_v;
        pready    = pr_v;
        prdata    = prd_v;
        pslverr   = perr_v;
    endtask

    initial begin
        logic               rst_v, pr_v, perr_v;
        logic [NREQ-1:0]    req_v, wr_v, exp_ack;
        logic [NREQ*AW-1:0] addr_v;
        logic [NREQ*DW-1:0] wd_v;
        logic [DW-1:0]      prd_v;
        bit                 exp_psel, exp_pen, in_access;

        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < NREQ; k++) begin
            active[k]   = 1'b0;
            op_write[k] = 1'b0;
            op_addr[k]  = '0;
            op_wdata[k] = '0;
        end
        busy = 1'b0; tx_idx = 0; tx_g = 0; tx_end = 0; tx_timeout = 1'b0;
        tx_write = 1'b0; tx_addr = '0; tx_wdata = '0;
        last = NREQ - 1; free_at = 0; ack_cyc = -1; ack_idx = 0;
        res_rdata = '0; held_rdata = '0; res_err = 1'b0; held_err = 1'b0;
        zero_cyc = 0; late_pready_cyc = -1; mid_resets = 0;
        req_v = '0;

        $display("[TB] start: NREQ=%0d TIMEOUT=%0d cycles=%0d", NREQ, TIMEOUT, NCYC);

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;

            // Reset: held for the first cycles, plus a few hits inside ACCESS.
            rst_v = 1'b1;
            if (n < 3) begin
                rst_v = 1'b0;
            end else if (mid_resets < 5 && n > 100 && busy && n >= tx_g + 2 &&
                         n <= tx_end && $urandom_range(0, 7) == 0) begin
                rst_v = 1'b0;
                mid_resets++;
            end

            // Requesters
            for (int k = 0; k < NREQ; k++) begin
                if (n == ack_cyc && ack_idx == k) begin
                    active[k] = 1'b0;
                    req_v[k]  = 1'($urandom_range(0, 1));
                end else if (active[k]) begin
                    req_v[k] = 1'b1;
                    if (busy && tx_idx == k) begin
                        op_write[k] = 1'($urandom_range(0, 1));
                        op_addr[k]  = AW'($urandom);
                        op_wdata[k] = DW'($urandom);
                    end
                end else if ($urandom_range(0, 2) != 0) begin
                    active[k]   = 1'b1;
                    req_v[k]    = 1'b1;
                    op_write[k] = 1'($urandom_range(0, 1));
                    op_addr[k]  = AW'($urandom);
                    op_wdata[k] = DW'($urandom);
                end else begin
                    req_v[k] = 1'b0;
                end
                wr_v[k]             = op_write[k];
                addr_v[k*AW +: AW]  = op_addr[k];
                wd_v[k*DW +: DW]    = op_wdata[k];
            end

            // Completer
            in_access = busy && n >= tx_g + 2 && n <= tx_end;
            if (in_access)                 pr_v = !tx_timeout && n == tx_end;
            else if (n == late_pready_cyc) pr_v = 1'b1;
            else                           pr_v = 1'($urandom_range(0, 1));
            prd_v  = DW'($urandom);
            perr_v = ($urandom_range(0, 3) == 0);

            applyStimulus(rst_v, req_v, wr_v, addr_v, wd_v, pr_v, prd_v, perr_v);

            @(negedge clk);

            // Expected outputs for cycle n
            if (n == ack_cyc) begin
                held_rdata = res_rdata;
                held_err   = res_err;
            end
            exp_psel = busy && n >= tx_g + 1 && n <= tx_end;
            exp_pen  = busy && n >= tx_g + 2 && n <= tx_end;
            exp_ack  = '0;
            if (n == ack_cyc) exp_ack[ack_idx] = 1'b1;

            checkOutput("psel",    64'(psel),    64'(exp_psel));
            checkOutput("penable", 64'(penable), 64'(exp_pen));
            checkOutput("ack",     64'(ack),     64'(exp_ack));
            checkOutput("rdata",   64'(rdata),   64'(held_rdata));
            checkOutput("slverr",  64'(slverr),  64'(held_err));
            if (exp_psel) begin
                checkOutput("paddr",  64'(paddr),  64'(tx_addr));
                checkOutput("pwrite", 64'(pwrite), 64'(tx_write));
                checkOutput("pwdata", 64'(pwdata), 64'(tx_wdata));
            end
            if (n == zero_cyc) begin
                checkOutput("reset_paddr",  64'(paddr),  64'd0);
                checkOutput("reset_pwrite", 64'(pwrite), 64'd0);
                checkOutput("reset_pwdata", 64'(pwdata), 64'd0);
            end

            // Advance the model with the inputs of cycle n
            if (!rst_v) begin
                busy       = 1'b0;
                free_at    = n + 1;
                last       = NREQ - 1;
                ack_cyc    = -1;
                held_rdata = '0;
                held_err   = 1'b0;
                zero_cyc   = n + 1;
            end else if (busy && n == tx_end) begin
                res_rdata = (tx_timeout || tx_write) ? '0 : prd_v;
                res_err   = tx_timeout ? 1'b1 : perr_v;
                ack_cyc   = n + 1;
                ack_idx   = tx_idx;
                busy      = 1'b0;
                free_at   = n + 1;
                if (tx_timeout) late_pready_cyc = n + 1;
            end else if (!busy && n >= free_at) begin
                int win;
                int r;
                win = -1;
                for (int i = 1; i <= NREQ; i++) begin
                    int c;
                    c = (last + i) % NREQ;
                    if (win < 0 && req_v[c] && !(n == ack_cyc && ack_idx == c)) win = c;
                end
                if (win >= 0) begin
                    busy     = 1'b1;
                    tx_idx   = win;
                    tx_g     = n;
                    tx_write = op_write[win];
                    tx_addr  = op_addr[win];
                    tx_wdata = op_wdata[win];
                    last     = win;
                    r = $urandom_range(0, 7);
                    if (r == 0) begin
                        tx_timeout = 1'b1;
                        tx_end     = n + 1 + TIMEOUT;
                    end else begin
                        tx_timeout = 1'b0;
                        tx_end     = n + 2 + ((r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3));
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
